// File: rtl/fare_account_responder.sv
// rtl/fare_account_responder.sv - fare gate tap responder with on-chip card account table
// Optional feature macro: FARE_CONCESSION_EN (per-card half-fare concession bit and write port).
module fare_account_responder #(
  parameter int NUM_CARDS     = 16,
  parameter int ID_W          = 4,
  parameter int BAL_W         = 12,
  parameter int FARE          = 300,
  parameter int INIT_BAL      = 0,
  parameter int DEBIT_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nfc,
  input  logic [ID_W-1:0]  card_id,
  input  logic             reduce_bal,
  output logic             resp_valid,
  output logic             card_active,
  output logic             fund_enough,
  output logic             debit_done,
  output logic             busy,
  input  logic             topup_valid,
  input  logic [ID_W-1:0]  topup_id,
  input  logic [BAL_W-1:0] topup_amt,
`ifdef FARE_CONCESSION_EN
  input  logic             conc_valid,
  input  logic [ID_W-1:0]  conc_id,
  input  logic             conc_val,
`endif
  input  logic             act_valid,
  input  logic [ID_W-1:0]  act_id,
  input  logic             act_val
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESPOND,
    S_WAIT_DEBIT,
    S_DEBIT
  } state_t;

  localparam int               CNT_W   = $clog2(DEBIT_TIMEOUT + 1);
  localparam logic [BAL_W-1:0] FARE_V  = BAL_W'(FARE);
  localparam logic [BAL_W-1:0] INIT_V  = BAL_W'(INIT_BAL);
  localparam logic [BAL_W-1:0] SAT_MAX = '1;

  state_t                 state;
  state_t                 state_nxt;
  logic [ID_W-1:0]        id_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BAL_W-1:0]       fare_q;
  logic [BAL_W-1:0]       tap_fare;
  logic [BAL_W-1:0]       bal_mem [NUM_CARDS];
  logic [NUM_CARDS-1:0]   act_mem;
`ifdef FARE_CONCESSION_EN
  logic [NUM_CARDS-1:0]   conc_mem;
`endif

  // Balance never drops below the fare between LOOKUP and DEBIT, so the
  // subtraction cannot wrap; only the top-up side can overflow.
  function automatic logic [BAL_W-1:0] sat_update(input logic [BAL_W-1:0] bal,
                                                  input logic [BAL_W-1:0] sub,
                                                  input logic [BAL_W-1:0] add);
    logic [BAL_W:0] sum;
    sum = {1'b0, bal} - {1'b0, sub} + {1'b0, add};
    return sum[BAL_W] ? SAT_MAX : sum[BAL_W-1:0];
  endfunction

  always_comb begin
    tap_fare = FARE_V;
`ifdef FARE_CONCESSION_EN
    if (conc_mem[id_q]) tap_fare = FARE_V >> 1;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (nfc) state_nxt = S_LOOKUP;
      S_LOOKUP:     state_nxt = S_RESPOND;
      S_RESPOND:    state_nxt = (card_active && fund_enough) ? S_WAIT_DEBIT : S_IDLE;
      S_WAIT_DEBIT: begin
        if (reduce_bal)
          state_nxt = S_DEBIT;
        else if (cnt_q == CNT_W'(DEBIT_TIMEOUT - 1))
          state_nxt = S_IDLE;
      end
      S_DEBIT:      state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      id_q        <= '0;
      cnt_q       <= '0;
      fare_q      <= '0;
      resp_valid  <= 1'b0;
      card_active <= 1'b0;
      fund_enough <= 1'b0;
      debit_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != S_IDLE);
      resp_valid <= (state == S_RESPOND);
      debit_done <= (state == S_DEBIT);
      cnt_q      <= (state == S_WAIT_DEBIT) ? cnt_q + CNT_W'(1) : '0;
      if (state == S_IDLE && nfc)
        id_q <= card_id;
      // The fare is latched so a later concession change cannot alter the debit.
      if (state == S_LOOKUP) begin
        card_active <= act_mem[id_q];
        fund_enough <= (bal_mem[id_q] >= tap_fare);
        fare_q      <= tap_fare;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CARDS; i++)
        bal_mem[i] <= INIT_V;
      act_mem <= '0;
`ifdef FARE_CONCESSION_EN
      conc_mem <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CARDS; i++) begin
        if ((state == S_DEBIT && id_q == ID_W'(i)) || (topup_valid && topup_id == ID_W'(i)))
          bal_mem[i] <= sat_update(bal_mem[i],
                                   (state == S_DEBIT && id_q == ID_W'(i)) ? fare_q : '0,
                                   (topup_valid && topup_id == ID_W'(i)) ? topup_amt : '0);
      end
      if (act_valid)
        act_mem[act_id] <= act_val;
`ifdef FARE_CONCESSION_EN
      if (conc_valid)
        conc_mem[conc_id] <= conc_val;
`endif
    end
  end

endmodule

// File: tb/tb_fare_account_responder.sv
// tb/tb_fare_account_responder.sv - self-checking bench for fare_account_responder
module tb_fare_account_responder;
  localparam int FARE = 300;
  localparam int MAXB = 4095;
  localparam int NC   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nfc = 1'b0;
  logic [3:0]  card_id = '0;
  logic        reduce_bal = 1'b0;
  logic        resp_valid, card_active, fund_enough, debit_done, busy;
  logic        topup_valid = 1'b0;
  logic [3:0]  topup_id = '0;
  logic [11:0] topup_amt = '0;
  logic        act_valid = 1'b0;
  logic [3:0]  act_id = '0;
  logic        act_val = 1'b0;

  int vectors = 0;
  int errors  = 0;
  int mbal [NC];
  bit mact [NC];

  fare_account_responder dut (
    .clk(clk), .rst_n(rst_n), .nfc(nfc), .card_id(card_id), .reduce_bal(reduce_bal),
    .resp_valid(resp_valid), .card_active(card_active), .fund_enough(fund_enough),
    .debit_done(debit_done), .busy(busy),
    .topup_valid(topup_valid), .topup_id(topup_id), .topup_amt(topup_amt),
    .act_valid(act_valid), .act_id(act_id), .act_val(act_val)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int x);
    return (x > MAXB) ? MAXB : x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      mbal[i] = 0;
      mact[i] = 1'b0;
    end
  endtask

  task automatic do_topup(input int id, input int amt);
    topup_valid = 1'b1; topup_id = 4'(id); topup_amt = 12'(amt);
    tick();
    topup_valid = 1'b0;
    mbal[id] = sat(mbal[id] + amt);
  endtask

  task automatic do_act(input int id, input bit v);
    act_valid = 1'b1; act_id = 4'(id); act_val = v;
    tick();
    act_valid = 1'b0;
    mact[id] = v;
  endtask

  // Returns at the cycle where resp_valid should be high (tap edge + 2).
  task automatic tap(input int id, output logic rv_early, output logic rv,
                     output logic ca, output logic fe);
    card_id = 4'(id); nfc = 1'b1;
    tick();
    nfc = 1'b0;
    tick();
    rv_early = resp_valid;
    tick();
    rv = resp_valid; ca = card_active; fe = fund_enough;
  endtask

  // Called in WAIT_DEBIT; optional top-up lands on the same edge as the debit.
  task automatic debit(input int id, input int amt, input bit nfc_noise,
                       output logic dd_early, output logic dd);
    reduce_bal = 1'b1; nfc = nfc_noise; card_id = 4'(id ^ 1);
    tick();
    reduce_bal = 1'b0; nfc = 1'b0;
    dd_early = debit_done;
    if (amt > 0) begin
      topup_valid = 1'b1; topup_id = 4'(id); topup_amt = 12'(amt);
    end
    tick();
    dd = debit_done;
    topup_valid = 1'b0;
    mbal[id] = sat(mbal[id] - FARE + amt);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vectors += 5;
    if (resp_valid !== 1'b0)  begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    if (card_active !== 1'b0) begin errors++; $display("FAIL reset_card_active: got %b want 0", card_active); end
    if (fund_enough !== 1'b0) begin errors++; $display("FAIL reset_fund_enough: got %b want 0", fund_enough); end
    if (debit_done !== 1'b0)  begin errors++; $display("FAIL reset_debit_done: got %b want 0", debit_done); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    model_reset();
    for (int i = 0; i < NC; i++) begin
      vectors++;
      if (int'(dut.bal_mem[i]) !== mbal[i]) begin
        errors++; $display("FAIL reset_balance[%0d]: got %0d want %0d", i, dut.bal_mem[i], mbal[i]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_accept();
    logic rve, rv, ca, fe, dde, dd;
    do_act(3, 1'b1);
    do_topup(3, 1000);
    tap(3, rve, rv, ca, fe);
    vectors += 5;
    if (rve !== 1'b0) begin errors++; $display("FAIL accept_resp_early: got %b want 0", rve); end
    if (rv !== 1'b1)  begin errors++; $display("FAIL accept_resp_valid: got %b want 1", rv); end
    if (ca !== 1'b1)  begin errors++; $display("FAIL accept_card_active: got %b want 1", ca); end
    if (fe !== 1'b1)  begin errors++; $display("FAIL accept_fund_enough: got %b want 1", fe); end
    if (busy !== 1'b1) begin errors++; $display("FAIL accept_busy_wait: got %b want 1", busy); end
    debit(3, 0, 1'b0, dde, dd);
    vectors += 4;
    if (dde !== 1'b0) begin errors++; $display("FAIL accept_debit_early: got %b want 0", dde); end
    if (dd !== 1'b1)  begin errors++; $display("FAIL accept_debit_done: got %b want 1", dd); end
    if (int'(dut.bal_mem[3]) !== 700) begin errors++; $display("FAIL accept_balance: got %0d want 700", dut.bal_mem[3]); end
    if (busy !== 1'b0) begin errors++; $display("FAIL accept_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_inactive();
    logic rve, rv, ca, fe;
    tap(5, rve, rv, ca, fe);
    vectors += 4;
    if (rv !== 1'b1)   begin errors++; $display("FAIL inactive_resp_valid: got %b want 1", rv); end
    if (ca !== 1'b0)   begin errors++; $display("FAIL inactive_card_active: got %b want 0", ca); end
    if (fe !== 1'b0)   begin errors++; $display("FAIL inactive_fund_enough: got %b want 0", fe); end
    if (busy !== 1'b0) begin errors++; $display("FAIL inactive_busy: got %b want 0", busy); end
    reduce_bal = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (debit_done !== 1'b0) begin errors++; $display("FAIL stray_reduce_debit_done: got %b want 0", debit_done); end
    end
    reduce_bal = 1'b0;
    vectors++;
    if (int'(dut.bal_mem[5]) !== mbal[5]) begin errors++; $display("FAIL stray_reduce_balance: got %0d want %0d", dut.bal_mem[5], mbal[5]); end
  endtask

  task automatic test_boundary();
    logic rve, rv, ca, fe, dde, dd;
    do_act(2, 1'b1);
    do_topup(2, 299);
    tap(2, rve, rv, ca, fe);
    vectors += 3;
    if (ca !== 1'b1)   begin errors++; $display("FAIL boundary299_card_active: got %b want 1", ca); end
    if (fe !== 1'b0)   begin errors++; $display("FAIL boundary299_fund_enough: got %b want 0", fe); end
    if (busy !== 1'b0) begin errors++; $display("FAIL boundary299_busy: got %b want 0", busy); end
    do_topup(2, 1);
    tap(2, rve, rv, ca, fe);
    vectors++;
    if (fe !== 1'b1) begin errors++; $display("FAIL boundary300_fund_enough: got %b want 1", fe); end
    debit(2, 0, 1'b0, dde, dd);
    vectors += 2;
    if (dd !== 1'b1) begin errors++; $display("FAIL boundary_debit_done: got %b want 1", dd); end
    if (int'(dut.bal_mem[2]) !== 0) begin errors++; $display("FAIL boundary_balance: got %0d want 0", dut.bal_mem[2]); end
  endtask

  task automatic test_timeout();
    logic rve, rv, ca, fe;
    tap(3, rve, rv, ca, fe);
    vectors++;
    if (!(ca === 1'b1 && fe === 1'b1)) begin errors++; $display("FAIL timeout_accept: got %b%b want 11", ca, fe); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      vectors += 2;
      if (busy !== (i < 8)) begin errors++; $display("FAIL timeout_busy_cycle%0d: got %b want %b", i, busy, i < 8); end
      if (debit_done !== 1'b0) begin errors++; $display("FAIL timeout_debit_done_cycle%0d: got %b want 0", i, debit_done); end
    end
    vectors++;
    if (int'(dut.bal_mem[3]) !== mbal[3]) begin errors++; $display("FAIL timeout_balance: got %0d want %0d", dut.bal_mem[3], mbal[3]); end
  endtask

  task automatic test_saturate();
    logic rve, rv, ca, fe, dde, dd;
    do_topup(1, 500);
    do_topup(1, 4095);
    vectors++;
    if (int'(dut.bal_mem[1]) !== 4095) begin errors++; $display("FAIL saturate_balance: got %0d want 4095", dut.bal_mem[1]); end
    tap(3, rve, rv, ca, fe);
    debit(3, 100, 1'b0, dde, dd);
    vectors += 2;
    if (dd !== 1'b1) begin errors++; $display("FAIL debit_topup_done: got %b want 1", dd); end
    if (int'(dut.bal_mem[3]) !== 500) begin errors++; $display("FAIL debit_topup_balance: got %0d want 500", dut.bal_mem[3]); end
  endtask

  task automatic test_random();
    logic rve, rv, ca, fe, dde, dd;
    int id, amt;
    bit exp_ca, exp_fe;
    for (int n = 0; n < 40; n++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        if ($urandom_range(0, 1) == 0)
          do_topup($urandom_range(0, NC - 1), $urandom_range(0, 800));
        else
          do_act($urandom_range(0, NC - 1), $urandom_range(0, 3) != 0);
      end
      id = $urandom_range(0, NC - 1);
      exp_ca = mact[id];
      exp_fe = (mbal[id] >= FARE);
      tap(id, rve, rv, ca, fe);
      vectors += 3;
      if (rv !== 1'b1)   begin errors++; $display("FAIL rand%0d_resp_valid: got %b want 1", n, rv); end
      if (ca !== exp_ca) begin errors++; $display("FAIL rand%0d_card_active: got %b want %b", n, ca, exp_ca); end
      if (fe !== exp_fe) begin errors++; $display("FAIL rand%0d_fund_enough: got %b want %b", n, fe, exp_fe); end
      if (exp_ca && exp_fe) begin
        if ($urandom_range(0, 3) == 0) begin
          for (int i = 0; i < 8; i++) tick();
        end else begin
          amt = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4095);
          debit(id, amt, $urandom_range(0, 1) == 1, dde, dd);
          vectors++;
          if (dd !== 1'b1) begin errors++; $display("FAIL rand%0d_debit_done: got %b want 1", n, dd); end
        end
      end
      vectors += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_busy_end: got %b want 0", n, busy); end
      if (int'(dut.bal_mem[id]) !== mbal[id]) begin
        errors++; $display("FAIL rand%0d_balance[%0d]: got %0d want %0d", n, id, dut.bal_mem[id], mbal[id]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic rve, rv, ca, fe;
    do_act(3, 1'b1);
    do_topup(3, 1000);
    tap(3, rve, rv, ca, fe);
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midreset_setup_busy: got %b want 1", busy); end
    reduce_bal = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors += 5;
    if (resp_valid !== 1'b0)  begin errors++; $display("FAIL midreset_resp_valid: got %b want 0", resp_valid); end
    if (card_active !== 1'b0) begin errors++; $display("FAIL midreset_card_active: got %b want 0", card_active); end
    if (fund_enough !== 1'b0) begin errors++; $display("FAIL midreset_fund_enough: got %b want 0", fund_enough); end
    if (debit_done !== 1'b0)  begin errors++; $display("FAIL midreset_debit_done: got %b want 0", debit_done); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    for (int i = 0; i < NC; i++) begin
      vectors++;
      if (int'(dut.bal_mem[i]) !== mbal[i]) begin
        errors++; $display("FAIL midreset_balance[%0d]: got %0d want %0d", i, dut.bal_mem[i], mbal[i]);
      end
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors += 2;
      if (debit_done !== 1'b0) begin errors++; $display("FAIL postreset_debit_done: got %b want 0", debit_done); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL postreset_busy: got %b want 0", busy); end
    end
    reduce_bal = 1'b0;
    vectors++;
    if (int'(dut.bal_mem[3]) !== 0) begin errors++; $display("FAIL postreset_balance: got %0d want 0", dut.bal_mem[3]); end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_inactive();
    test_boundary();
    test_timeout();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
